// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline hazard controller: register index, FSM state
// and the packed stage-register control bundle with its fixed encodings.
package cpu_types_pkg;

    localparam int unsigned DEF_REG_W = 5;
    localparam int unsigned DEF_CNT_W = 32;

    typedef logic [DEF_REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN,
        DMEM_WAIT,
        HALTED
    } hz_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_en;
        logic memwb_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_NORMAL = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                         idex_en: 1'b1, idex_flush: 1'b0,
                                         exmem_en: 1'b1, exmem_flush: 1'b0,
                                         memwb_en: 1'b1, memwb_flush: 1'b0};
    localparam hz_ctrl_t CTRL_RESET  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
                                         idex_en: 1'b0, idex_flush: 1'b1,
                                         exmem_en: 1'b0, exmem_flush: 1'b1,
                                         memwb_en: 1'b0, memwb_flush: 1'b1};
    localparam hz_ctrl_t CTRL_FROZEN = '0;

    // Whole pipeline holds; only the WB register takes a bubble.
    function automatic hz_ctrl_t ctrl_busy();
        hz_ctrl_t c;
        c = '0;
        c.memwb_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: hazard inputs and stage-register controls.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic             mem_req;
    logic             idex_memread;
    logic [REG_W-1:0] idex_rt;
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic             ex_redirect;
    logic             mem_halt;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             exmem_flush;
    logic             memwb_en;
    logic             memwb_flush;
    logic             halt;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output ihit, dhit, mem_req, idex_memread, idex_rt, ifid_rs, ifid_rt,
               ex_redirect, mem_halt,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               exmem_flush, memwb_en, memwb_flush, halt, stall_cycles, flush_count
    );

    modport slave (
        input  ihit, dhit, mem_req, idex_memread, idex_rt, ifid_rs, ifid_rt,
               ex_redirect, mem_halt,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               exmem_flush, memwb_en, memwb_flush, halt, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; sticks at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: resolves cache waits, load-use, EX redirects and halt into
// per-stage enable/flush controls, and keeps saturating stall/flush counters.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
) (
    input logic                    CLK,
    input logic                    RST,
    pipeline_hazard_ctrl_if.slave  hz
);
    hz_state_t r_state;
    logic      r_ihit_lat;

    hz_state_t w_next;
    logic      w_lat_next;
    hz_ctrl_t  w_ctrl;
    logic      w_busy;
    logic      w_ihit_eff;
    logic      w_lu;
    logic      w_redirect_taken;
    logic      w_stall_inc;
    logic      w_flush_inc;

    assign w_lu = hz.idex_memread && (hz.idex_rt != '0) &&
                  ((hz.idex_rt == hz.ifid_rs) || (hz.idex_rt == hz.ifid_rt));

    always_comb begin
        w_ctrl           = CTRL_NORMAL;
        w_next           = r_state;
        w_lat_next       = 1'b0;
        w_redirect_taken = 1'b0;
        w_ihit_eff       = hz.ihit | ((r_state == DMEM_WAIT) & r_ihit_lat);
        // Once waiting, only dhit releases the pipeline, whatever mem_req shows.
        w_busy           = (r_state == DMEM_WAIT) ? ~hz.dhit : (hz.mem_req & ~hz.dhit);

        if (RST) begin
            w_ctrl = CTRL_RESET;
        end else begin
            unique case (r_state)
                HALTED: begin
                    w_ctrl = CTRL_FROZEN;
                end
                default: begin
                    w_next = RUN;
                    if (hz.mem_halt && !w_busy) begin
                        w_ctrl.pc_en       = 1'b0;
                        w_ctrl.ifid_flush  = 1'b1;
                        w_ctrl.idex_flush  = 1'b1;
                        w_ctrl.exmem_flush = 1'b1;
                        w_ctrl.memwb_en    = 1'b1;
                        w_next             = HALTED;
                    end else if (w_busy) begin
                        w_ctrl     = ctrl_busy();
                        w_lat_next = w_ihit_eff;
                        w_next     = DMEM_WAIT;
                    end else if (hz.ex_redirect) begin
                        w_ctrl.ifid_flush = 1'b1;
                        w_ctrl.idex_flush = 1'b1;
                        w_redirect_taken  = 1'b1;
                    end else if (w_lu) begin
                        w_ctrl.pc_en      = 1'b0;
                        w_ctrl.ifid_en    = 1'b0;
                        w_ctrl.idex_flush = 1'b1;
                    end else if (!w_ihit_eff) begin
                        w_ctrl.pc_en      = 1'b0;
                        w_ctrl.ifid_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= RUN;
            r_ihit_lat <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ihit_lat <= w_lat_next;
        end
    end

    assign w_stall_inc = !RST && (r_state != HALTED) && !w_ctrl.pc_en;
    assign w_flush_inc = !RST && w_redirect_taken;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (w_stall_inc),
        .count (hz.stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (w_flush_inc),
        .count (hz.flush_count)
    );

    assign hz.pc_en       = w_ctrl.pc_en;
    assign hz.ifid_en     = w_ctrl.ifid_en;
    assign hz.ifid_flush  = w_ctrl.ifid_flush;
    assign hz.idex_en     = w_ctrl.idex_en;
    assign hz.idex_flush  = w_ctrl.idex_flush;
    assign hz.exmem_en    = w_ctrl.exmem_en;
    assign hz.exmem_flush = w_ctrl.exmem_flush;
    assign hz.memwb_en    = w_ctrl.memwb_en;
    assign hz.memwb_flush = w_ctrl.memwb_flush;
    assign hz.halt        = !RST && (r_state == HALTED);
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: each vector pushes its hand-computed response into a queue;
// a negedge monitor pops and compares against a 32-bit and a 4-bit counter instance.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) if_main ();
    pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(4))  if_sat ();

    pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(32)) u_dut (
        .CLK (clk),
        .RST (rst),
        .hz  (if_main.slave)
    );

    pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(4)) u_dut_sat (
        .CLK (clk),
        .RST (rst),
        .hz  (if_sat.slave)
    );

    assign if_sat.ihit         = if_main.ihit;
    assign if_sat.dhit         = if_main.dhit;
    assign if_sat.mem_req      = if_main.mem_req;
    assign if_sat.idex_memread = if_main.idex_memread;
    assign if_sat.idex_rt      = if_main.idex_rt;
    assign if_sat.ifid_rs      = if_main.ifid_rs;
    assign if_sat.ifid_rt      = if_main.ifid_rt;
    assign if_sat.ex_redirect  = if_main.ex_redirect;
    assign if_sat.mem_halt     = if_main.mem_halt;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush, halt}
    localparam logic [9:0] RSTV  = 10'b0010101010;
    localparam logic [9:0] NORM  = 10'b1101010100;
    localparam logic [9:0] BUSY  = 10'b0000000010;
    localparam logic [9:0] LU    = 10'b0001110100;
    localparam logic [9:0] MISS  = 10'b0111010100;
    localparam logic [9:0] REDIR = 10'b1111110100;
    localparam logic [9:0] HGO   = 10'b0111111100;
    localparam logic [9:0] HLTD  = 10'b0000000001;

    typedef struct {
        logic [9:0]  outs;
        int unsigned s;
        int unsigned f;
        bit          chk;
        string       name;
    } exp_t;

    exp_t q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    function automatic int unsigned sat15(input int unsigned v);
        return (v > 15) ? 15 : v;
    endfunction

    // Monitor
    always @(negedge clk) begin
        exp_t       e;
        logic [9:0] got;
        if (q.size() > 0) begin
            e   = q.pop_front();
            got = {if_main.pc_en, if_main.ifid_en, if_main.ifid_flush, if_main.idex_en,
                   if_main.idex_flush, if_main.exmem_en, if_main.exmem_flush,
                   if_main.memwb_en, if_main.memwb_flush, if_main.halt};
            checks++;
            if (got !== e.outs) begin
                errors++;
                $display("FAIL %s ctrl got %b want %b", e.name, got, e.outs);
            end
            if (e.chk) begin
                checks++;
                if (if_main.stall_cycles !== e.s) begin
                    errors++;
                    $display("FAIL %s stall_cycles got %0d want %0d", e.name, if_main.stall_cycles, e.s);
                end
                checks++;
                if (if_main.flush_count !== e.f) begin
                    errors++;
                    $display("FAIL %s flush_count got %0d want %0d", e.name, if_main.flush_count, e.f);
                end
                checks++;
                if (if_sat.stall_cycles !== 4'(sat15(e.s))) begin
                    errors++;
                    $display("FAIL %s sat stall got %0d want %0d", e.name, if_sat.stall_cycles, sat15(e.s));
                end
                checks++;
                if (if_sat.flush_count !== 4'(sat15(e.f))) begin
                    errors++;
                    $display("FAIL %s sat flush got %0d want %0d", e.name, if_sat.flush_count, sat15(e.f));
                end
            end
        end
    end

    task automatic step(input logic r, input logic ih, input logic dh, input logic mr,
                        input logic rd, input logic [4:0] xrt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic redir, input logic mh,
                        input logic [9:0] outs, input int unsigned s, input int unsigned f,
                        input bit chk, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst                  = r;
        if_main.ihit         = ih;
        if_main.dhit         = dh;
        if_main.mem_req      = mr;
        if_main.idex_memread = rd;
        if_main.idex_rt      = xrt;
        if_main.ifid_rs      = rs;
        if_main.ifid_rt      = rt;
        if_main.ex_redirect  = redir;
        if_main.mem_halt     = mh;
        e.outs = outs; e.s = s; e.f = f; e.chk = chk; e.name = name;
        q.push_back(e);
    endtask

    initial begin
        rst                  = 1'b1;
        if_main.ihit         = 1'b1;
        if_main.dhit         = 1'b0;
        if_main.mem_req      = 1'b0;
        if_main.idex_memread = 1'b0;
        if_main.idex_rt      = '0;
        if_main.ifid_rs      = '0;
        if_main.ifid_rt      = '0;
        if_main.ex_redirect  = 1'b0;
        if_main.mem_halt     = 1'b0;

        //   rst ih dh mr rd xrt   rs    rt    rdr mh  outs   S  F  chk name
        step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, RSTV,  0, 0, 0, "rst0");
        step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, RSTV,  0, 0, 1, "rst1");
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM,  0, 0, 1, "run");
        step(0, 1, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, LU,    0, 0, 1, "lu_rs");
        step(0, 1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, NORM,  1, 0, 1, "lu_r0");
        step(0, 1, 0, 0, 1, 5'd5, 5'd3, 5'd5, 0, 0, LU,    1, 0, 1, "lu_rt");
        step(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, BUSY,  2, 0, 1, "dmiss1");
        step(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, BUSY,  3, 0, 1, "dmiss2");
        step(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, BUSY,  4, 0, 1, "dmiss3");
        step(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM,  5, 0, 1, "dhit_lat");
        step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, MISS,  5, 0, 1, "lat_clr");
        step(0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0, REDIR, 6, 0, 1, "redir_lu");
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM,  6, 1, 1, "post_redir");
        step(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1, 0, BUSY,  6, 1, 1, "busy_redir");
        step(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 1, 0, REDIR, 7, 1, 1, "dhit_redir");
        step(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, BUSY,  7, 2, 1, "busy_prerst");
        step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, RSTV,  8, 2, 1, "rst_wait");
        step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, MISS,  0, 0, 1, "no_leftover");
        step(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, BUSY,  1, 0, 1, "halt_busy");
        step(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, HGO,   2, 0, 1, "halt_go");
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1, 1, 5'd8, 5'd8, 5'd8, 1, 0, HLTD, 3, 0, 1, "halted");
        end
        step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, RSTV,  3, 0, 1, "rst_sat");
        for (int i = 0; i < 23; i++) begin
            step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, MISS, i, 0, 1, "sat_miss");
        end
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM, 23, 0, 1, "sat_hold");

        begin
            int unsigned budget;
            budget = 0;
            while (q.size() != 0 && budget < 10) begin
                @(posedge clk);
                budget++;
            end
            if (q.size() != 0) begin
                errors++;
                $display("FAIL drain queue left %0d want 0", q.size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
